// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM-stage data access unit for the pipelined MIPS core. Holds a
//            byte-writable data RAM and performs byte/halfword/word loads and
//            stores with sign/zero extension on loads, a configurable number
//            of memory wait states, and a valid/ready handshake with stall.
//            Branch resolution (zero & branch_in) is also done here.
// Ports    : clk, rst_n            - clock / async active-low reset
//            req_valid/req_ready   - request handshake (one access in flight)
//            req_write, req_size,  - store flag, 00 B / 01 H / 10,11 W,
//            req_unsigned          - zero-extend loads when set
//            addr_in, write_data   - byte address, LSB-aligned store data
//            data_out, resp_valid, - load result and one-cycle completion
//            resp_misalign         - misalignment flag (qualified by valid)
//            stall                 - req_valid & ~req_ready
//            zero, branch_in,      - branch resolution inputs
//            branch_out            - zero & branch_in (combinational)
// Options  : MEM_ACCESS_ALIGN_CHECK_EN - when defined, misaligned halfword and
//            word accesses are flagged and do not write the RAM; otherwise
//            the offending low address bits are forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int B      = 32,
    parameter int ADDR_W = 10,
    parameter int WAIT   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [B-1:0] addr_in,
    input  logic [B-1:0] write_data,
    input  logic         zero,
    input  logic         branch_in,
    output logic [B-1:0] data_out,
    output logic         resp_valid,
    output logic         resp_misalign,
    output logic         stall,
    output logic         branch_out
);

    localparam int         c_LANES     = B / 8;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  is_write_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;
    logic                  misalign_q;
    logic [B-1:0]          rdata_q;
    logic [B-1:0]          mem_q [0:(2**ADDR_W)-1];

    logic                  w_accept;
    logic                  w_is_word;
    logic                  w_is_half;
    logic                  w_misalign;
    logic [1:0]            w_lane;
    logic [c_LANES-1:0]    w_be;
    logic [B-1:0]          w_wdata;
    logic [ADDR_W-1:0]     w_word_idx;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [B-1:0]          w_load;
    logic                  w_unused;

    assign w_accept   = req_valid & (state_q == ST_IDLE);
    assign w_is_word  = req_size[1];
    assign w_is_half  = (req_size == 2'b01);
    assign w_word_idx = addr_in[ADDR_W+1:2];
    assign w_unused   = ^addr_in[B-1:ADDR_W+2];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half & addr_in[0]) | (w_is_word & (|addr_in[1:0]));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane selection forces the offending low bits to zero, so with the
    // alignment check disabled a misaligned access silently snaps down.
    always_comb begin
        w_lane  = addr_in[1:0];
        w_be    = '0;
        w_wdata = write_data;
        if (w_is_word) begin
            w_lane  = 2'b00;
            w_be    = '1;
            w_wdata = write_data;
        end else if (w_is_half) begin
            w_lane  = {addr_in[1], 1'b0};
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{write_data[15:0]}};
        end else begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{write_data[7:0]}};
        end
    end

    // RAM port: stores commit and loads are read on the accept edge.
    // Not reset, so the array infers as block RAM with byte enables.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (req_write && !w_misalign) begin
                for (int i = 0; i < c_LANES; i++) begin
                    if (w_be[i]) begin
                        mem_q[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[w_word_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        is_write_q <= req_write;
                        uns_q      <= req_unsigned;
                        size_q     <= req_size;
                        lane_q     <= w_lane;
                        misalign_q <= w_misalign;
                        if (WAIT > 0) begin
                            state_q <= ST_BUSY;
                            cnt_q   <= c_WAIT_LOAD;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Load extraction from the held RAM word using the latched lane/size.
    always_comb begin
        w_byte = rdata_q[{lane_q, 3'b000} +: 8];
        w_half = rdata_q[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   w_load = {{(B-8){~uns_q & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{(B-16){~uns_q & w_half[15]}}, w_half};
            default: w_load = rdata_q;
        endcase
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_misalign = resp_valid & misalign_q;
    assign data_out      = (resp_valid && !is_write_q && !misalign_q) ? w_load : '0;
    assign stall         = req_valid & ~req_ready;
    assign branch_out    = zero & branch_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Two instances share
//            the request fields: u_w0 (WAIT=0) and u_w3 (WAIT=3), each with
//            its own req_valid. Expected load results are queued when a
//            request is accepted and popped when resp_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] write_data = '0;
    logic        zero = 1'b0;
    logic        branch_in = 1'b0;
    logic        valid0 = 1'b0;
    logic        valid3 = 1'b0;

    logic        ready0, ready3, rv0, rv3, mis0, mis3, stall0, stall3, br0, br3;
    logic [31:0] data0, data3;

    bit          sel = 1'b0;
    logic        w_ready, w_rv, w_mis, w_stall;
    logic [31:0] w_data;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } exp_t;
    exp_t sb_q[$];

    int    errors = 0;
    int    checks = 0;
    time   acc_t  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.B(32), .ADDR_W(10), .WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .addr_in(addr_in), .write_data(write_data), .zero(zero), .branch_in(branch_in),
        .data_out(data0), .resp_valid(rv0), .resp_misalign(mis0), .stall(stall0),
        .branch_out(br0)
    );

    mem_access_stage #(.B(32), .ADDR_W(10), .WAIT(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .addr_in(addr_in), .write_data(write_data), .zero(zero), .branch_in(branch_in),
        .data_out(data3), .resp_valid(rv3), .resp_misalign(mis3), .stall(stall3),
        .branch_out(br3)
    );

    always_comb begin
        w_ready = sel ? ready3 : ready0;
        w_rv    = sel ? rv3    : rv0;
        w_mis   = sel ? mis3   : mis0;
        w_stall = sel ? stall3 : stall0;
        w_data  = sel ? data3  : data0;
    end

    // One access on the selected instance; expectation is queued on accept.
    task automatic do_access(input bit s, input bit wr, input logic [1:0] sz,
                             input bit uns, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] ed, input bit em, input bit hold,
                             input string nm);
        int   lat;
        int   exp_lat;
        bit   got;
        exp_t e;
        exp_lat = s ? 4 : 1;
        @(negedge clk);
        sel = s; req_write = wr; req_size = sz; req_unsigned = uns;
        addr_in = a; write_data = wd;
        if (s) valid3 = 1'b1; else valid0 = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            if (w_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s accept: req_ready never 1", nm);
            valid0 = 1'b0; valid3 = 1'b0;
            return;
        end
        @(posedge clk);
        acc_t = $time;
        e.data = ed; e.mis = em;
        sb_q.push_back(e);
        #1;
        if (!hold) begin valid0 = 1'b0; valid3 = 1'b0; end
        got = 1'b0;
        lat = 1;
        while (!got && lat <= 40) begin
            checks++;
            if (w_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_busy: req_ready=%b expected 0 (cycle +%0d)", nm, w_ready, lat);
            end
            if (hold) begin
                checks++;
                if (w_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stall: stall=%b expected 1 (cycle +%0d)", nm, w_stall, lat);
                end
            end
            if (w_rv === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        valid0 = 1'b0; valid3 = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s resp: resp_valid never seen", nm);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (w_data !== e.data) begin
            errors++;
            $display("FAIL %s data: data_out=%h expected %h", nm, w_data, e.data);
        end
        checks++;
        if (w_mis !== e.mis) begin
            errors++;
            $display("FAIL %s misalign: resp_misalign=%b expected %b", nm, w_mis, e.mis);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", nm, lat, exp_lat);
        end
        @(posedge clk); #1;
        checks++;
        if (w_rv !== 1'b0 || w_ready !== 1'b1 || w_data !== 32'h0) begin
            errors++;
            $display("FAIL %s after_resp: resp_valid=%b req_ready=%b data_out=%h expected 0/1/0",
                     nm, w_rv, w_ready, w_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rv0 !== 1'b0 || rv3 !== 1'b0 || ready0 !== 1'b1 || ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: rv0=%b rv3=%b ready0=%b ready3=%b expected 0 0 1 1", rv0, rv3, ready0, ready3);
        end
        checks++;
        if (data0 !== 32'h0 || data3 !== 32'h0 || mis0 !== 1'b0 || mis3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data0=%h data3=%h mis0=%b mis3=%b expected zeros", data0, data3, mis0, mis3);
        end
        checks++;
        if (stall0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: stall=%b expected 0", stall0);
        end
        valid0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        do_access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, "sw_10");
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, "lw_10");
    endtask

    task automatic test_byte();
        do_access(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0, 0, 0, "sb_13");
        do_access(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0, "lb_13");
        do_access(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 0, "lbu_13");
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0, "lw_10b");
    endtask

    task automatic test_half();
        do_access(0, 1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0, 0, 0, "sw_14");
        do_access(0, 1, 2'b01, 0, 32'h16, 32'h00008234, 32'h0, 0, 0, "sh_16");
        do_access(0, 0, 2'b01, 0, 32'h16, 32'h0, 32'hFFFF8234, 0, 0, "lh_16");
        do_access(0, 0, 2'b01, 1, 32'h16, 32'h0, 32'h00008234, 0, 0, "lhu_16");
        do_access(0, 0, 2'b10, 0, 32'h14, 32'h0, 32'h82343344, 0, 0, "lw_14");
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        do_access(0, 0, 2'b01, 0, 32'h15, 32'h0, 32'h0, 1, 0, "lh_15");
        do_access(0, 1, 2'b01, 0, 32'h15, 32'h00005566, 32'h0, 1, 0, "sh_15");
        do_access(0, 0, 2'b10, 0, 32'h14, 32'h0, 32'h82343344, 0, 0, "lw_14_keep");
        do_access(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 0, "lw_12");
`else
        do_access(0, 0, 2'b01, 0, 32'h15, 32'h0, 32'h00003344, 0, 0, "lh_15");
        do_access(0, 1, 2'b01, 0, 32'h15, 32'h00005566, 32'h0, 0, 0, "sh_15");
        do_access(0, 0, 2'b10, 0, 32'h14, 32'h0, 32'h82345566, 0, 0, "lw_14_new");
        do_access(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h80ADBEEF, 0, 0, "lw_12");
`endif
    endtask

    task automatic test_wait3();
        do_access(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0, "w3_sw_20");
        do_access(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, "w3_lw_20");
        do_access(1, 0, 2'b11, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0, "w3_size11");
        do_access(1, 0, 2'b00, 1, 32'h21, 32'h0, 32'h000000F0, 0, 0, "w3_lbu_21");
    endtask

    // A request shown during RESP must wait for the following IDLE cycle.
    task automatic test_resp_window();
        @(negedge clk);
        sel = 0; req_write = 0; req_size = 2'b10; req_unsigned = 0; addr_in = 32'h10;
        valid0 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rv0 !== 1'b1 || data0 !== 32'h80ADBEEF || stall0 !== 1'b1 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL resp_win_1: rv=%b data=%h stall=%b ready=%b expected 1 80adbeef 1 0",
                     rv0, data0, stall0, ready0);
        end
        req_size = 2'b00; req_unsigned = 1; addr_in = 32'h13;
        @(posedge clk); #1;
        checks++;
        if (rv0 !== 1'b0 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL resp_win_2: rv=%b ready=%b expected 0 1", rv0, ready0);
        end
        @(posedge clk); #1;
        checks++;
        if (rv0 !== 1'b1 || data0 !== 32'h00000080) begin
            errors++;
            $display("FAIL resp_win_3: rv=%b data=%h expected 1 00000080", rv0, data0);
        end
        valid0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        time t0;
        do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0, "b2b0_a");
        t0 = acc_t;
        do_access(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0, "b2b0_b");
        checks++;
        if (acc_t - t0 != 20) begin
            errors++;
            $display("FAIL b2b_w0: accept spacing %0t expected 20", acc_t - t0);
        end
        do_access(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0, "b2b3_a");
        t0 = acc_t;
        do_access(1, 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000CAFE, 0, 0, "b2b3_b");
        checks++;
        if (acc_t - t0 != 50) begin
            errors++;
            $display("FAIL b2b_w3: accept spacing %0t expected 50", acc_t - t0);
        end
    endtask

    // Reset in the middle of a WAIT=3 access: k=0 in-flight load, k=1 store.
    task automatic test_reset_midflight();
        bit seen;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sel = 1; req_size = 2'b10; req_unsigned = 0;
            req_write = (k == 1);
            addr_in = (k == 1) ? 32'h24 : 32'h20;
            write_data = 32'h0BADC0DE;
            valid3 = 1'b1;
            @(posedge clk); #1;
            valid3 = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            checks++;
            if (ready3 !== 1'b1 || rv3 !== 1'b0 || data3 !== 32'h0) begin
                errors++;
                $display("FAIL midrst_%0d_in: ready=%b rv=%b data=%h expected 1 0 0", k, ready3, rv3, data3);
            end
            @(negedge clk);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                if (rv3 !== 1'b0 || data3 !== 32'h0 || ready3 !== 1'b1) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL midrst_%0d_after: response or busy seen after reset (rv=%b ready=%b)", k, rv3, ready3);
            end
        end
        do_access(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0, "midrst_lw_20");
        do_access(1, 0, 2'b10, 0, 32'h24, 32'h0, 32'h0BADC0DE, 0, 0, "midrst_lw_24");
    endtask

    task automatic test_branch();
        logic exp_b;
        for (int r = 1; r >= 0; r--) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                rst_n = r[0];
                zero = i[0]; branch_in = i[1];
                exp_b = i[0] & i[1];
                #1;
                checks++;
                if (br0 !== exp_b || br3 !== exp_b) begin
                    errors++;
                    $display("FAIL branch r=%0d z=%0d b=%0d: br0=%b br3=%b expected %b",
                             r, i[0], i[1], br0, br3, exp_b);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1; zero = 1'b0; branch_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wait3();
        test_resp_window();
        test_back_to_back();
        test_reset_midflight();
        test_branch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM-stage data access unit for the pipelined MIPS core, sitting between the EX/MEM and MEM/WB registers. It contains an inferred byte-writable data RAM. It supports byte, halfword and word loads and stores, with sign or zero extension on loads, and a configurable memory wait-state count. A valid/ready handshake with a stall output lets the pipeline freeze while an access is in flight. Branch resolution (`zero && branch_in`) is kept in this stage.

## Interface

Reset is asynchronous, active-low (`rst_n`); single clock `clk`.

Parameters:
- `B`, 32: data/address width; only 32 is supported.
- `ADDR_W`, 10: word-address bits; RAM depth is 2^ADDR_W words.
- `WAIT`, 0: extra wait cycles per access, 0..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  access request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `addr_in`  in  B  byte address.
- `write_data`  in  B  store data, LSB-aligned.
- `zero`  in  1  ALU zero flag.
- `branch_in`  in  1  branch instruction flag.
- `data_out`  out  B  load result; valid while `resp_valid` is high.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_misalign`  out  1  access was misaligned, qualified by `resp_valid`.
- `stall`  out  1  `req_valid & ~req_ready`.
- `branch_out`  out  1  `zero & branch_in`.

## Operation

- Little-endian addressing:
  - word index = `addr_in[ADDR_W+1:2]`; upper address bits are ignored.
  - byte lane = `addr_in[1:0]`.
- FSM states:
  - **IDLE:** `req_ready`=1. When `req_valid` is high, the request is accepted. Go to BUSY if WAIT>0, otherwise to RESP.
  - **BUSY:** counter loads WAIT-1 on entry and decrements each cycle. At 0, go to RESP.
  - **RESP:** `resp_valid`=1 for exactly one cycle, then return to IDLE.
  - `req_ready`=0 in BUSY and RESP. Requests are not pipelined.
- Stores are committed to RAM on the accept edge.
  - SB writes `write_data[7:0]` to lane `addr[1:0]`.
  - SH writes `write_data[15:0]` to lanes {2*`addr[1]`+1, 2*`addr[1]`}.
  - SW writes all four lanes.
- Loads:
  - The RAM word is read synchronously at the accept edge and held in a register.
  - The extracted byte or halfword is sign- or zero-extended per `req_unsigned`.
  - The result drives `data_out` in RESP.
- `data_out` is 0 for store responses and outside RESP.
- `branch_out` is purely combinational and independent of the FSM and reset.
- RAM contents are not reset or initialised. Reading an unwritten location gives X in simulation.

## Timing

- Reset values:
  - state IDLE, `req_ready`=1, `resp_valid`=0, `data_out`=0, `resp_misalign`=0, wait counter 0.
  - `stall` follows `req_valid`/`req_ready`.
- Latency:
  - A request accepted at edge N gives `resp_valid` during cycle N+1+WAIT.
  - Throughput is one access per 2+WAIT cycles.
- Holding `req_valid` while `req_ready`=0 keeps `stall`=1. The request must be held stable until accepted.
- Reset asserted mid-access (BUSY or RESP):
  - The in-flight load is discarded and no `resp_valid` is produced.
  - A store already committed at the accept edge remains in RAM.
- A request presented in the RESP cycle is not accepted. It is accepted in the following IDLE cycle.

## Configuration

- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - A halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, is accepted and follows normal FSM timing.
  - The RAM is not written.
  - The response gives `resp_misalign`=1 and `data_out`=0.
- `MEM_ACCESS_ALIGN_CHECK_EN` undefined:
  - Offending low address bits are forced to 0: halfword uses lane pair `addr[1]`, word uses lane 0.
  - `resp_misalign` is tied to 0.

## Test plan

- WAIT=0: SW 0xDEADBEEF @0x10, then LW @0x10 accepted at edge N -> `resp_valid` in cycle N+1, `data_out`=0xDEADBEEF; `req_ready` low in cycle N+1 only.
- SB `write_data`=0x00000080 @0x13 -> LB @0x13 = 0xFFFFFF80, LBU @0x13 = 0x00000080, LW @0x10 = 0x80ADBEEF.
- SH 0x00008234 @0x16 -> LH @0x16 = 0xFFFF8234, LHU = 0x00008234. LH @0x15:
  - with macro: `resp_misalign`=1, `data_out`=0, and a subsequent SH to 0x15 leaves memory unchanged.
  - without macro: returns the halfword at 0x14.
- WAIT=3: LW accepted at edge N with `req_valid` held high -> `resp_valid` in cycle N+4 only; `req_ready`=0 and `stall`=1 in cycles N+1..N+4.
- WAIT=3: `rst_n` pulsed low in cycle N+2 -> no `resp_valid`, `data_out`=0, `req_ready`=1 after release; the next LW completes normally with correct data.
- `zero`/`branch_in` swept over all 4 combinations, including during reset -> `branch_out`=1 only for 1/1, in the same cycle.
